// File: rtl/cu_sequencer.sv
// ---------------------------------------------------------------------------
// cu_sequencer
//   Two-cycle control unit that sits directly in front of the datapath.
//   FETCH latches the instruction word addressed by the PC. EXEC decodes it,
//   drives the datapath control word and moves the PC to its next value.
//   A HLT instruction parks the unit in HALT until reset.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_in     instruction word at instr_addr (combinational ROM read)
//   zero         datapath zero flag, sampled during EXEC of a branch
//   address_in   datapath address_out (value of register rsA)
//   instr_addr   current PC
//   regWrite     register file write enable (EXEC only)
//   rsA/rsB/rd   register selects
//   constant_in  3-bit immediate
//   MB           1: constant_in feeds operand B, 0: register B
//   MD           1: memory data is written back, 0: EU result
//   op_select    EU operation
//   mem_write    data-memory write strobe (EXEC only)
//   halted       high while parked in HALT
//   illegal_op   one-cycle pulse when EXEC sees the undefined class 101
// ---------------------------------------------------------------------------
module cu_sequencer #(
    parameter int                   BUS_WIDTH = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          instr_in,
    input  logic                 zero,
    input  logic [BUS_WIDTH-1:0] address_in,
    output logic [BUS_WIDTH-1:0] instr_addr,
    output logic                 regWrite,
    output logic [2:0]           rsA,
    output logic [2:0]           rsB,
    output logic [2:0]           rd,
    output logic [2:0]           constant_in,
    output logic                 MB,
    output logic                 MD,
    output logic [3:0]           op_select,
    output logic                 mem_write,
    output logic                 halted,
    output logic                 illegal_op
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [2:0] C_ALU  = 3'b000;
    localparam logic [2:0] C_LD   = 3'b001;
    localparam logic [2:0] C_ST   = 3'b010;
    localparam logic [2:0] C_HLT  = 3'b011;
    localparam logic [2:0] C_IMM  = 3'b100;
    localparam logic [2:0] C_ILL  = 3'b101;
    localparam logic [2:0] C_BR   = 3'b110;
    localparam logic [2:0] C_JMP  = 3'b111;

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_pc;
    logic [15:0]          r_ir;

    logic [2:0]           w_class;
    logic [3:0]           w_op;
    logic                 w_exec;
    logic signed [5:0]    w_br_off;
    logic [BUS_WIDTH-1:0] w_br_off_ext;
    logic                 w_br_taken;
    logic [BUS_WIDTH-1:0] w_pc_next;

    assign w_class = r_ir[15:13];
    assign w_op    = r_ir[12:9];
    assign w_exec  = (r_state == S_EXEC);

    // Branch offset is split across the rd and rsB fields so that rsA stays
    // free to select the register whose zero-ness is tested.
    assign w_br_off     = {r_ir[8:6], r_ir[2:0]};
    assign w_br_off_ext = {{(BUS_WIDTH-6){w_br_off[5]}}, w_br_off};

    // op[0] chooses the polarity: 0 = branch on zero, 1 = branch on non-zero.
    assign w_br_taken = r_ir[9] ? ~zero : zero;

    always_comb begin
        w_pc_next = r_pc + BUS_WIDTH'(1);
        case (w_class)
            C_BR:    if (w_br_taken) w_pc_next = r_pc + w_br_off_ext;
            C_JMP:   w_pc_next = address_in;
            C_HLT:   w_pc_next = r_pc;
            default: w_pc_next = r_pc + BUS_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= instr_in;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_pc    <= w_pc_next;
                    r_state <= (w_class == C_HLT) ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Field outputs follow IR in every state; with IR cleared by reset they
    // all read zero while reset is held.
    assign instr_addr  = r_pc;
    assign rd          = r_ir[8:6];
    assign rsA         = r_ir[5:3];
    assign rsB         = r_ir[2:0];
    assign constant_in = r_ir[2:0];
    assign MB          = (w_class == C_IMM);
    assign MD          = (w_class == C_LD);
    // Branches and jumps run MOVA (0000) so rsA appears on the EU result.
    assign op_select   = ((w_class == C_ALU) || (w_class == C_IMM)) ? w_op : 4'b0000;

    // Strobes only fire in EXEC so a reset mid-instruction cancels them.
    assign regWrite   = w_exec && ((w_class == C_ALU) || (w_class == C_IMM) ||
                                   (w_class == C_LD));
    assign mem_write  = w_exec && (w_class == C_ST);
    assign illegal_op = w_exec && (w_class == C_ILL);
    assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_in;
    logic        zero;
    logic [15:0] address_in;
    logic [15:0] instr_addr;
    logic        regWrite;
    logic [2:0]  rsA, rsB, rd, constant_in;
    logic        MB, MD;
    logic [3:0]  op_select;
    logic        mem_write, halted, illegal_op;

    int total = 0;
    int bad   = 0;

    logic [15:0] rom [256];
    logic [15:0] regs [8] = '{16'd0, 16'd1, 16'd5, 16'd9, 16'd4, 16'd5, 16'd6, 16'd7};
    logic [15:0] opb;
    logic [15:0] result;

    cu_sequencer #(.BUS_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .zero(zero),
        .address_in(address_in), .instr_addr(instr_addr), .regWrite(regWrite),
        .rsA(rsA), .rsB(rsB), .rd(rd), .constant_in(constant_in), .MB(MB), .MD(MD),
        .op_select(op_select), .mem_write(mem_write), .halted(halted),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign instr_in = rom[instr_addr[7:0]];

    // Minimal datapath: MOVA (0000) and ADD (0010); loads return 0xBEEF.
    always_comb begin
        opb    = MB ? {13'd0, constant_in} : regs[rsB];
        result = (op_select == 4'b0010) ? regs[rsA] + opb : regs[rsA];
        if (MD) result = 16'hBEEF;
    end

    always @(posedge clk) begin
        if (regWrite) regs[rd] <= result;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0453;
        rom[1] = 16'h8417;
        zero = 1'b0;
        address_in = 16'h0000;
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (instr_addr !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", instr_addr); end
        total++; if ({regWrite, mem_write, illegal_op, halted, MB, MD} !== 6'b0) begin bad++; $display("FAIL rst_strobes got=%b exp=000000", {regWrite, mem_write, illegal_op, halted, MB, MD}); end
        total++; if ({rsA, rsB, rd, constant_in, op_select} !== 16'h0) begin bad++; $display("FAIL rst_fields got=%h exp=0000", {rsA, rsB, rd, constant_in, op_select}); end
        rst_n = 1'b1;
        tick();
        total++; if (regWrite !== 1'b1) begin bad++; $display("FAIL pre_abort_wr got=%b exp=1", regWrite); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({regWrite, op_select, rsA} !== 8'h00) begin bad++; $display("FAIL abort_outs got=%h exp=00", {regWrite, op_select, rsA}); end
        total++; if (instr_addr !== 16'h0000) begin bad++; $display("FAIL abort_pc got=%h exp=0000", instr_addr); end
        tick();
        total++; if (regs[1] !== 16'd1) begin bad++; $display("FAIL abort_r1 got=%0d exp=1", regs[1]); end
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL add_fetch_wr got=%b exp=0", regWrite); end
        tick();
        total++; if (regWrite !== 1'b1) begin bad++; $display("FAIL add_wr got=%b exp=1", regWrite); end
        total++; if (op_select !== 4'b0010) begin bad++; $display("FAIL add_op got=%b exp=0010", op_select); end
        total++; if ({rsA, rsB, rd, MB, MD} !== {3'd2, 3'd3, 3'd1, 2'b00}) begin bad++; $display("FAIL add_fields got=%b exp=%b", {rsA, rsB, rd, MB, MD}, {3'd2, 3'd3, 3'd1, 2'b00}); end
        total++; if (instr_addr !== 16'h0000) begin bad++; $display("FAIL add_exec_pc got=%h exp=0000", instr_addr); end
        tick();
        total++; if (instr_addr !== 16'h0001) begin bad++; $display("FAIL add_pc got=%h exp=0001", instr_addr); end
        total++; if (regs[1] !== 16'd14) begin bad++; $display("FAIL add_r1 got=%0d exp=14", regs[1]); end
        total++; if (regWrite !== 1'b0) begin bad++; $display("FAIL add_after_wr got=%b exp=0", regWrite); end
    endtask

    task automatic test_imm;
        tick();
        total++; if ({MB, constant_in, regWrite, rd} !== {1'b1, 3'b111, 1'b1, 3'd0}) begin bad++; $display("FAIL imm_ctrl got=%b exp=%b", {MB, constant_in, regWrite, rd}, {1'b1, 3'b111, 1'b1, 3'd0}); end
        total++; if (op_select !== 4'b0010) begin bad++; $display("FAIL imm_op got=%b exp=0010", op_select); end
        tick();
        total++; if (regs[0] !== 16'd12) begin bad++; $display("FAIL imm_r0 got=%0d exp=12", regs[0]); end
        total++; if (instr_addr !== 16'h0002) begin bad++; $display("FAIL imm_pc got=%h exp=0002", instr_addr); end
    endtask

    task automatic test_ld;
        rom[0] = 16'h20C8;
        reset_dut();
        tick();
        total++; if ({MD, regWrite, MB, rsA, rd} !== {1'b1, 1'b1, 1'b0, 3'd1, 3'd3}) begin bad++; $display("FAIL ld_ctrl got=%b exp=%b", {MD, regWrite, MB, rsA, rd}, {1'b1, 1'b1, 1'b0, 3'd1, 3'd3}); end
        tick();
        total++; if (regs[3] !== 16'hBEEF) begin bad++; $display("FAIL ld_r3 got=%h exp=beef", regs[3]); end
        total++; if (instr_addr !== 16'h0001) begin bad++; $display("FAIL ld_pc got=%h exp=0001", instr_addr); end
    endtask

    task automatic test_branch;
        rom[0] = 16'hC1C6;
        rom[1] = 16'hC203;
        zero = 1'b1;
        reset_dut();
        tick();
        total++; if ({regWrite, mem_write, op_select} !== 6'b0) begin bad++; $display("FAIL br_ctrl got=%b exp=000000", {regWrite, mem_write, op_select}); end
        tick();
        total++; if (instr_addr !== 16'hFFFE) begin bad++; $display("FAIL brz_taken_pc got=%h exp=fffe", instr_addr); end
        zero = 1'b0;
        reset_dut();
        repeat (2) tick();
        total++; if (instr_addr !== 16'h0001) begin bad++; $display("FAIL brz_not_pc got=%h exp=0001", instr_addr); end
        repeat (2) tick();
        total++; if (instr_addr !== 16'h0004) begin bad++; $display("FAIL brnz_taken_pc got=%h exp=0004", instr_addr); end
    endtask

    task automatic test_jmp_st;
        rom[0]     = 16'hE000;
        rom[8'h34] = 16'h400A;
        address_in = 16'h1234;
        reset_dut();
        tick();
        total++; if ({regWrite, op_select} !== 5'b0) begin bad++; $display("FAIL jmp_ctrl got=%b exp=00000", {regWrite, op_select}); end
        tick();
        total++; if (instr_addr !== 16'h1234) begin bad++; $display("FAIL jmp_pc got=%h exp=1234", instr_addr); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL st_fetch_mw got=%b exp=0", mem_write); end
        tick();
        total++; if ({mem_write, regWrite, MB, rsA, rsB} !== {1'b1, 1'b0, 1'b0, 3'd1, 3'd2}) begin bad++; $display("FAIL st_ctrl got=%b exp=%b", {mem_write, regWrite, MB, rsA, rsB}, {1'b1, 1'b0, 1'b0, 3'd1, 3'd2}); end
        tick();
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL st_after_mw got=%b exp=0", mem_write); end
        total++; if (instr_addr !== 16'h1235) begin bad++; $display("FAIL st_pc got=%h exp=1235", instr_addr); end
        address_in = 16'h0000;
    endtask

    task automatic test_illegal_halt;
        rom[0] = 16'hA000;
        rom[1] = 16'h6000;
        reset_dut();
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_fetch got=%b exp=0", illegal_op); end
        tick();
        total++; if ({illegal_op, regWrite} !== 2'b10) begin bad++; $display("FAIL ill_exec got=%b exp=10", {illegal_op, regWrite}); end
        tick();
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_after got=%b exp=0", illegal_op); end
        total++; if (instr_addr !== 16'h0001) begin bad++; $display("FAIL ill_pc got=%h exp=0001", instr_addr); end
        tick();
        total++; if ({halted, regWrite} !== 2'b00) begin bad++; $display("FAIL hlt_exec got=%b exp=00", {halted, regWrite}); end
        tick();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL hlt_flag got=%b exp=1", halted); end
        total++; if (instr_addr !== 16'h0001) begin bad++; $display("FAIL hlt_pc got=%h exp=0001", instr_addr); end
        rom[1] = 16'h0453;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({halted, instr_addr, regWrite, mem_write, illegal_op} !== {1'b1, 16'h0001, 3'b000}) begin
                bad++;
                $display("FAIL hlt_hold%0d got=%h exp=%h", i, {halted, instr_addr, regWrite, mem_write, illegal_op}, {1'b1, 16'h0001, 3'b000});
            end
        end
        rst_n = 1'b0;
        #1;
        total++; if ({halted, instr_addr} !== 17'h0) begin bad++; $display("FAIL hlt_rst got=%h exp=00000", {halted, instr_addr}); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if ({illegal_op, instr_addr} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL restart got=%h exp=10000", {illegal_op, instr_addr}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_ld();
        test_branch();
        test_jmp_st();
        test_illegal_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Multi-cycle control unit directly upstream of the datapath top.
- Fetches 16-bit instructions from an asynchronous-read instruction memory using an internal PC, then decodes them.
- Drives the datapath control word (regWrite, rsA, rsB, rd, constant_in, MB, MD, op_select) and a data-memory write strobe.
- Consumes the datapath's zero flag and address_out for conditional branches and register-indirect jumps.

Parameters:
- BUS_WIDTH, 16: width of PC, instr_addr and address_in.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_in  input  16  instruction word for instr_addr; combinational ROM read.
- zero  input  1  datapath zero flag, valid combinationally in EXEC.
- address_in  input  BUS_WIDTH  datapath address_out (register rsA value).
- instr_addr  output  BUS_WIDTH  current PC.
- regWrite  output  1  register file write enable.
- rsA, rsB, rd  output  3 each  register selects.
- constant_in  output  3  immediate value.
- MB  output  1  1 selects constant_in, 0 selects register B.
- MD  output  1  1 selects data_in from memory, 0 selects the EU result.
- op_select  output  4  EU operation.
- mem_write  output  1  data-memory write strobe.
- halted  output  1  high while in HALT.
- illegal_op  output  1  one-cycle pulse for an undefined class.

Behaviour:
- Instruction fields:
  - class = IR[15:13]; op = IR[12:9]; rd = IR[8:6]; rsA = IR[5:3]; rsB = IR[2:0].
  - constant_in = IR[2:0] in all states.
- FSM states:
  - FETCH: IR <= instr_in; next state is EXEC.
  - EXEC: apply the decoded control word; update PC; next state is FETCH, or HALT for class 011.
  - HALT: terminal; exit only through reset.
- Every instruction takes 2 cycles. A register write commits at the rising edge that ends EXEC.
- Control outputs are combinational from IR and state.
  - Outside EXEC, regWrite, mem_write and illegal_op are forced to 0.
  - rsA, rsB, rd, op_select, MB and MD still reflect IR in all states; they are don't-care for the datapath.
- Decode in EXEC (PC <= PC+1 unless stated otherwise):
  - 000 register ALU op: op_select=op, MB=0, MD=0, regWrite=1.
  - 100 immediate ALU op: op_select=op, MB=1, MD=0, regWrite=1.
  - 001 LD: MD=1, regWrite=1. The memory address is address_in, driven by rsA.
  - 010 ST: mem_write=1, regWrite=0, MB=0. Address comes from rsA and data from rsB.
  - 110 branch: op_select=0000 (MOVA of rsA), regWrite=0.
    - Branch condition: op[0]=0 means branch if zero=1 (BRZ); op[0]=1 means branch if zero=0 (BRNZ).
    - Taken: PC <= PC + sext({IR[8:6],IR[2:0]}), a 6-bit signed offset covering -32..+31. The result wraps modulo 2^BUS_WIDTH.
  - 111 JMP: regWrite=0, op_select=0000; PC <= address_in.
  - 011 HLT: regWrite=0; PC holds; next state HALT.
  - 101 undefined: behaves as a NOP with regWrite=0; illegal_op=1 for the EXEC cycle; PC+1.
- PC increment wraps: all-ones + 1 = 0.
- Reset (asynchronous, any state including mid-EXEC):
  - state=FETCH, PC=RESET_PC, IR=0.
  - All outputs 0 except instr_addr=RESET_PC. halted=0.
  - A write pending in EXEC is aborted; no register or memory write occurs.
- Reset release: the first FETCH edge is the first rising clk after rst_n goes high.
- HALT: all strobes 0, halted=1, PC frozen; instr_in is ignored.

Test Plan:
1. Assert rst_n=0 mid-EXEC of an ADD → outputs 0 immediately, instr_addr=0x0000, the destination register is unchanged; after release the first fetch is from 0x0000.
2. ROM[0]=0x0453 (ADD r1←r2+r3, class 000, op 0010) → regWrite=1, op_select=0010, rsA=2, rsB=3, rd=1 only in the 2nd cycle; PC=0x0001 after 2 edges.
3. ROM[1]=0x8417 (immediate ADD, rd=0, rsA=2, constant 7) → MB=1, constant_in=111, regWrite=1; r0 = r2 + 7.
4. At PC=0x0000, BRZ with offset 6'b111110, zero=1 → PC=0xFFFE (wrap). Same instruction with zero=0 → PC=0x0001.
5. JMP with address_in=0x1234 → PC=0x1234, regWrite=0. ST → mem_write high exactly one cycle and regWrite=0.
6. Class 101 → illegal_op pulses 1 cycle and PC+1. HLT → halted=1, PC frozen for 10 cycles; rst_n pulse restarts at RESET_PC.
